// File: rtl/meanfilter_scheduler.sv
// rtl/meanfilter_scheduler.sv - one sliding-mean filter datapath shared round-robin across NUM_CH channels
// Each granted sample runs IDLE (fetch) -> CALC -> WRITE (writeback + result strobe).
module meanfilter_scheduler #(
  parameter int DATA_WITH  = 24,
  parameter int MEAN_Level = 7,
  parameter int NUM_CH     = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic [NUM_CH-1:0]               iValid,
  input  logic [NUM_CH*DATA_WITH-1:0]     iData,
  input  logic                            iClrOvr,
  output logic [DATA_WITH+MEAN_Level-1:0] oData,
  output logic [$clog2(NUM_CH)-1:0]       oCh,
  output logic                            oValid,
  output logic [NUM_CH-1:0]               oOverrun
);

  localparam int AW = DATA_WITH + MEAN_Level;
  localparam int CW = $clog2(NUM_CH);

  typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;

  state_t                             state_q, state_d;
  logic [NUM_CH-1:0]                  pending_q, pending_d;
  logic [NUM_CH-1:0][DATA_WITH-1:0]   smp_q, smp_d;
  logic [NUM_CH-1:0]                  overrun_q, overrun_d;
  logic [NUM_CH-1:0]                  primed_q, primed_d;
  logic [NUM_CH-1:0][AW-1:0]          acc_q, acc_d;
  logic [NUM_CH-1:0][DATA_WITH-1:0]   last_q, last_d;
  logic [CW-1:0]                      rr_q, rr_d;
  logic [CW-1:0]                      ch_q, ch_d;
  logic [DATA_WITH-1:0]               x_q, x_d;
  logic [AW-1:0]                      a_q, a_d;
  logic [DATA_WITH-1:0]               p_q, p_d;
  logic                               en_q, en_d;
  logic [AW-1:0]                      accn_q, accn_d;
  logic [AW-1:0]                      odata_q, odata_d;
  logic [CW-1:0]                      och_q, och_d;
  logic                               ovalid_q, ovalid_d;

  logic                               gnt_any;
  logic [CW-1:0]                      gnt_ch;
  logic                               grant;
  int                                 arb_idx;
  logic [NUM_CH-1:0]                  ovr_set;
  logic [AW-1:0]                      x_ext;
  logic [AW-1:0]                      acc_new;
  logic                               crossline;

  // rr_q holds the last granted channel; reset to NUM_CH-1 so the first search starts at 0
  always_comb begin
    gnt_any = 1'b0;
    gnt_ch  = '0;
    arb_idx = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      arb_idx = (int'(rr_q) + i) % NUM_CH;
      if (!gnt_any && pending_q[arb_idx]) begin
        gnt_any = 1'b1;
        gnt_ch  = CW'(arb_idx);
      end
    end
  end

  assign grant = (state_q == IDLE) && gnt_any;

  // A wrap of the grating position between quadrants 11 and 00 must not be averaged across
  assign crossline = ((p_q[DATA_WITH-1 -: 2] == 2'b11) && (x_q[DATA_WITH-1 -: 2] == 2'b00)) ||
                     ((p_q[DATA_WITH-1 -: 2] == 2'b00) && (x_q[DATA_WITH-1 -: 2] == 2'b11));
  assign x_ext     = AW'(x_q);
  assign acc_new   = (!en_q || !primed_q[ch_q] || crossline) ? (x_ext << MEAN_Level)
                                                             : (a_q - (a_q >> MEAN_Level) + x_ext);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    smp_d     = smp_q;
    primed_d  = primed_q;
    acc_d     = acc_q;
    last_d    = last_q;
    rr_d      = rr_q;
    ch_d      = ch_q;
    x_d       = x_q;
    a_d       = a_q;
    p_d       = p_q;
    en_d      = en_q;
    accn_d    = accn_q;
    odata_d   = odata_q;
    och_d     = och_q;
    ovalid_d  = 1'b0;
    ovr_set   = '0;

    for (int k = 0; k < NUM_CH; k++) begin
      if (iValid[k]) begin
        pending_d[k] = 1'b1;
        smp_d[k]     = iData[k*DATA_WITH +: DATA_WITH];
        ovr_set[k]   = pending_q[k] && !(grant && (gnt_ch == CW'(k)));
      end else if (grant && (gnt_ch == CW'(k))) begin
        pending_d[k] = 1'b0;
      end
    end
    overrun_d = (overrun_q & ~{NUM_CH{iClrOvr}}) | ovr_set;

    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          ch_d    = gnt_ch;
          x_d     = smp_q[gnt_ch];
          a_d     = acc_q[gnt_ch];
          p_d     = last_q[gnt_ch];
          en_d    = en;
          rr_d    = gnt_ch;
          state_d = CALC;
        end
      end
      CALC: begin
        accn_d  = acc_new;
        state_d = WRITE;
      end
      WRITE: begin
        acc_d[ch_q]    = accn_q;
        last_d[ch_q]   = x_q;
        primed_d[ch_q] = en_q;
        odata_d        = accn_q;
        och_d          = ch_q;
        ovalid_d       = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      smp_q     <= '0;
      overrun_q <= '0;
      primed_q  <= '0;
      acc_q     <= '0;
      last_q    <= '0;
      rr_q      <= CW'(NUM_CH - 1);
      ch_q      <= '0;
      x_q       <= '0;
      a_q       <= '0;
      p_q       <= '0;
      en_q      <= 1'b0;
      accn_q    <= '0;
      odata_q   <= '0;
      och_q     <= '0;
      ovalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      smp_q     <= smp_d;
      overrun_q <= overrun_d;
      primed_q  <= primed_d;
      acc_q     <= acc_d;
      last_q    <= last_d;
      rr_q      <= rr_d;
      ch_q      <= ch_d;
      x_q       <= x_d;
      a_q       <= a_d;
      p_q       <= p_d;
      en_q      <= en_d;
      accn_q    <= accn_d;
      odata_q   <= odata_d;
      och_q     <= och_d;
      ovalid_q  <= ovalid_d;
    end
  end

  assign oData    = odata_q;
  assign oCh      = och_q;
  assign oValid   = ovalid_q;
  assign oOverrun = overrun_q;

endmodule

// File: tb/tb_meanfilter_scheduler.sv
// tb/tb_meanfilter_scheduler.sv - self-checking bench for meanfilter_scheduler
// Directed scenarios plus a randomized run against a transaction-level reference model.
module tb_meanfilter_scheduler;
  localparam int DW = 24;
  localparam int L  = 7;
  localparam int N  = 4;
  localparam int AW = DW + L;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b1;
  logic [N-1:0]    iv = '0;
  logic [N*DW-1:0] idata = '0;
  logic            clr = 1'b0;
  logic [AW-1:0]   odata;
  logic [CW-1:0]   och;
  logic            ovalid;
  logic [N-1:0]    ovr;

  meanfilter_scheduler #(.DATA_WITH(DW), .MEAN_Level(L), .NUM_CH(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .iValid(iv), .iData(idata), .iClrOvr(clr),
    .oData(odata), .oCh(och), .oValid(ovalid), .oOverrun(ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            c;
    logic [CW-1:0] ch;
    logic [AW-1:0] d;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  res_t obs_q[$];
  res_t exp_q[$];

  // Reference model: pending flags, last sample and filter state per channel
  bit            m_pend[N];
  logic [DW-1:0] m_smp[N];
  logic [AW-1:0] m_acc[N];
  logic [DW-1:0] m_last[N];
  bit            m_primed[N];
  int            m_busy;
  int            m_rr;
  logic [N-1:0]  m_ovr;

  function automatic logic [AW-1:0] model_filter(int ch, logic [DW-1:0] x, bit e);
    logic [AW-1:0] r;
    logic [1:0]    pt;
    logic [1:0]    xt;
    bit            wrap;
    pt   = m_last[ch][DW-1 -: 2];
    xt   = x[DW-1 -: 2];
    wrap = (pt == 2'b11 && xt == 2'b00) || (pt == 2'b00 && xt == 2'b11);
    if (!e || !m_primed[ch] || wrap) r = AW'(x) * (1 << L);
    else                             r = m_acc[ch] - m_acc[ch] / (1 << L) + AW'(x);
    m_acc[ch]    = r;
    m_last[ch]   = x;
    m_primed[ch] = e;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_pend[k] = 0; m_smp[k] = '0; m_acc[k] = '0; m_last[k] = '0; m_primed[k] = 0;
    end
    m_busy = 0;
    m_rr   = N - 1;
    m_ovr  = '0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic model_step(input logic [N-1:0] v, input logic [N*DW-1:0] d, input bit c, input bit e);
    int   g;
    res_t r;
    logic [N-1:0] set;
    g = -1;
    set = '0;
    if (m_busy > 0) m_busy--;
    else
      for (int i = 1; i <= N; i++)
        if (g < 0 && m_pend[(m_rr + i) % N]) g = (m_rr + i) % N;
    if (g >= 0) begin
      r.c  = cyc + 2;
      r.ch = CW'(g);
      r.d  = model_filter(g, m_smp[g], e);
      exp_q.push_back(r);
      m_pend[g] = 0;
      m_rr      = g;
      m_busy    = 2;
    end
    for (int k = 0; k < N; k++)
      if (v[k]) begin
        if (m_pend[k]) set[k] = 1'b1;
        m_pend[k] = 1;
        m_smp[k]  = d[k*DW +: DW];
      end
    m_ovr = (c ? '0 : m_ovr) | set;
  endtask

  function automatic logic [N*DW-1:0] put(int k, logic [DW-1:0] x);
    logic [N*DW-1:0] v;
    v = '0;
    v[k*DW +: DW] = x;
    return v;
  endfunction

  task automatic cycle(input logic [N-1:0] v, input logic [N*DW-1:0] d, input bit c);
    res_t r;
    iv = v; idata = d; clr = c;
    @(posedge clk);
    cyc++;
    model_step(v, d, c, en);
    #1;
    if (ovalid) begin
      r.c = cyc; r.ch = och; r.d = odata;
      obs_q.push_back(r);
    end
    iv = '0; clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle('0, '0, 1'b0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL reset_ovalid got %0b want 0", ovalid); end
    checks++; if (odata !== '0) begin errors++; $display("FAIL reset_odata got %0h want 0", odata); end
    checks++; if (och !== '0) begin errors++; $display("FAIL reset_och got %0d want 0", och); end
    checks++; if (ovr !== '0) begin errors++; $display("FAIL reset_ovr got %0b want 0", ovr); end
  endtask

  task automatic test_single();
    int c0;
    apply_reset();
    c0 = cyc;
    cycle(4'b0001, put(0, 24'h100000), 1'b0);
    idle(6);
    c0 = c0 + 10;
    cycle(4'b0001, put(0, 24'h100080), 1'b0);
    idle(6);
    checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL single_count got %0d want 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      checks++; if (obs_q[0].c != c0 - 10 + 4) begin errors++; $display("FAIL single_latency got %0d want 4", obs_q[0].c - c0 + 10); end
      checks++; if (obs_q[0].ch !== 0) begin errors++; $display("FAIL single_ch got %0d want 0", obs_q[0].ch); end
      checks++; if (obs_q[0].d !== 31'h8000000) begin errors++; $display("FAIL single_prime got %0h want 8000000", obs_q[0].d); end
      checks++; if (obs_q[1].d !== 31'h8000080) begin errors++; $display("FAIL single_filter got %0h want 8000080", obs_q[1].d); end
    end
  endtask

  task automatic test_all_ch();
    int c0;
    logic [DW-1:0] xs[N];
    logic [N*DW-1:0] d;
    apply_reset();
    d = '0;
    for (int k = 0; k < N; k++) begin
      xs[k] = DW'(24'h010203 * (k + 1));
      d = d | put(k, xs[k]);
    end
    c0 = cyc;
    cycle(4'b1111, d, 1'b0);
    idle(14);
    checks++; if (obs_q.size() != N) begin errors++; $display("FAIL allch_count got %0d want %0d", obs_q.size(), N); end
    for (int k = 0; k < N && k < obs_q.size(); k++) begin
      checks++; if (obs_q[k].ch !== CW'(k)) begin errors++; $display("FAIL allch_order got %0d want %0d", obs_q[k].ch, k); end
      checks++; if (obs_q[k].d !== AW'(xs[k]) * 128) begin errors++; $display("FAIL allch_data got %0h want %0h", obs_q[k].d, AW'(xs[k]) * 128); end
      checks++; if (obs_q[k].c != c0 + 4 + 3 * k) begin errors++; $display("FAIL allch_time got %0d want %0d", obs_q[k].c - c0, 4 + 3 * k); end
    end
    checks++; if (ovr !== '0) begin errors++; $display("FAIL allch_ovr got %0b want 0", ovr); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    cycle(4'b0001, put(0, 24'h000100), 1'b0);
    cycle(4'b0001, put(0, 24'h000200), 1'b0);
    idle(8);
    checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      checks++; if (obs_q[0].d !== 31'h8000) begin errors++; $display("FAIL b2b_first got %0h want 8000", obs_q[0].d); end
      checks++; if (obs_q[1].d !== 31'h8100) begin errors++; $display("FAIL b2b_second got %0h want 8100", obs_q[1].d); end
      checks++; if (obs_q[1].c - obs_q[0].c != 3) begin errors++; $display("FAIL b2b_spacing got %0d want 3", obs_q[1].c - obs_q[0].c); end
    end
    checks++; if (ovr !== '0) begin errors++; $display("FAIL b2b_ovr got %0b want 0", ovr); end
  endtask

  task automatic test_overrun();
    apply_reset();
    cycle(4'b0010, put(1, 24'h000005), 1'b0);
    cycle(4'b0100, put(2, 24'h000010), 1'b0);
    cycle(4'b0100, put(2, 24'h000020), 1'b0);
    idle(8);
    checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL ovr_count got %0d want 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      checks++; if (obs_q[1].ch !== 2 || obs_q[1].d !== 31'h1000) begin errors++; $display("FAIL ovr_result got ch%0d %0h want ch2 1000", obs_q[1].ch, obs_q[1].d); end
    end
    checks++; if (ovr !== 4'b0100) begin errors++; $display("FAIL ovr_flag got %0b want 0100", ovr); end
    cycle('0, '0, 1'b1);
    checks++; if (ovr !== '0) begin errors++; $display("FAIL ovr_clear got %0b want 0", ovr); end
  endtask

  task automatic test_crossline();
    apply_reset();
    cycle(4'b0010, put(1, 24'hFFFFF0), 1'b0); idle(4);
    cycle(4'b0010, put(1, 24'h000010), 1'b0); idle(4);
    cycle(4'b0010, put(1, 24'h000020), 1'b0); idle(4);
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL cross_count got %0d want 3", obs_q.size()); end
    if (obs_q.size() == 3) begin
      checks++; if (obs_q[0].d !== 31'h7FFFF800) begin errors++; $display("FAIL cross_prime got %0h want 7ffff800", obs_q[0].d); end
      checks++; if (obs_q[1].d !== 31'h800) begin errors++; $display("FAIL cross_wrap got %0h want 800", obs_q[1].d); end
      checks++; if (obs_q[2].d !== 31'h810) begin errors++; $display("FAIL cross_next got %0h want 810", obs_q[2].d); end
    end
  endtask

  task automatic test_enable();
    apply_reset();
    cycle(4'b1000, put(3, 24'h001000), 1'b0); idle(4);
    cycle(4'b1000, put(3, 24'h001100), 1'b0); idle(4);
    en = 1'b0;
    cycle(4'b1000, put(3, 24'h001200), 1'b0);
    cycle('0, '0, 1'b0);
    en = 1'b1;
    idle(4);
    cycle(4'b1000, put(3, 24'h001300), 1'b0); idle(4);
    checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL en_count got %0d want 4", obs_q.size()); end
    if (obs_q.size() == 4) begin
      checks++; if (obs_q[1].d !== 31'h80100) begin errors++; $display("FAIL en_filter got %0h want 80100", obs_q[1].d); end
      checks++; if (obs_q[2].d !== 31'h90000) begin errors++; $display("FAIL en_pass got %0h want 90000", obs_q[2].d); end
      checks++; if (obs_q[3].d !== 31'h98000) begin errors++; $display("FAIL en_reprime got %0h want 98000", obs_q[3].d); end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cycle(4'b0001, put(0, 24'h000100), 1'b0); idle(4);
    cycle(4'b0011, put(0, 24'h000300) | put(1, 24'h000005), 1'b0);
    cycle(4'b0010, put(1, 24'h000006), 1'b0);
    rst_n = 1'b0;
    #2;
    checks++; if (ovalid !== 1'b0 || odata !== '0 || och !== '0) begin errors++; $display("FAIL midrst_out got %0b %0h %0d want 0 0 0", ovalid, odata, och); end
    checks++; if (ovr !== '0) begin errors++; $display("FAIL midrst_ovr got %0b want 0", ovr); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL midrst_dropped got %0d want 0", obs_q.size()); end
    cycle(4'b0001, put(0, 24'h000400), 1'b0); idle(5);
    checks++; if (obs_q.size() != 1 || obs_q[0].d !== 31'h20000) begin errors++; $display("FAIL midrst_prime got n%0d want 1 result 20000", obs_q.size()); end
  endtask

  task automatic test_random();
    logic [N-1:0]    v;
    logic [N*DW-1:0] d;
    int              n;
    apply_reset();
    repeat (800) begin
      v = '0;
      d = '0;
      for (int k = 0; k < N; k++) begin
        v[k] = ($urandom_range(0, 5) == 0);
        d[k*DW +: DW] = DW'($urandom);
      end
      en = ($urandom_range(0, 7) != 0);
      cycle(v, d, $urandom_range(0, 15) == 0);
      checks++; if (ovr !== m_ovr) begin errors++; $display("FAIL rand_ovr cyc %0d got %0b want %0b", cyc, ovr, m_ovr); end
    end
    en = 1'b1;
    idle(12);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i].ch !== exp_q[i].ch || obs_q[i].d !== exp_q[i].d || obs_q[i].c != exp_q[i].c) begin
        errors++;
        $display("FAIL rand_result %0d got ch%0d %0h @%0d want ch%0d %0h @%0d", i,
                 obs_q[i].ch, obs_q[i].d, obs_q[i].c, exp_q[i].ch, exp_q[i].d, exp_q[i].c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_ch();
    test_back_to_back();
    test_overrun();
    test_crossline();
    test_enable();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
